// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg: shared state encoding, sizing helpers and result flags for chunked_serial_adder
package chunked_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [1:0] flags(input logic c_msb_in, input logic c_out, input logic all_zero);
    return {c_msb_in ^ c_out, all_zero};
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple adder built from full-adder cells
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             cin,
  output logic [CHUNK-1:0] s_chunk,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ w_c[i];
    assign w_c[i+1]   = (a_chunk[i] & b_chunk[i]) | (w_c[i] & (a_chunk[i] ^ b_chunk[i]));
  end
  assign cout     = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];
endmodule

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle WIDTH-bit adder, CHUNK bits per clock, valid/ready on both sides
// CHUNKED_ADDER_SUBTRACT_EN adds a 'sub' input computing a + ~b + 1.
module chunked_serial_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
`ifdef CHUNKED_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_w(NCHUNK);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic [CHUNK-1:0] w_s;
  logic             w_cout, w_cmsb, w_accept, w_last, w_c_in;
  logic [WIDTH-1:0] w_b_in, w_acc_next;
  logic [1:0]       w_flags;

`ifdef CHUNKED_ADDER_SUBTRACT_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub | carryin;
`else
  assign w_b_in = b;
  assign w_c_in = carryin;
`endif

  assign in_ready   = reset_n && (r_state == IDLE || (r_state == DONE && out_ready));
  assign out_valid  = r_state == DONE;
  assign w_accept   = in_valid && in_ready;
  assign w_last     = r_idx == IDX_W'(NCHUNK - 1);
  // Operands shift down one chunk per cycle; finished chunks enter the accumulator from the top.
  assign w_acc_next = (WIDTH'(w_s) << (WIDTH - CHUNK)) | (r_acc >> CHUNK);
  assign w_flags    = flags(w_cmsb, w_cout, w_acc_next == '0);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_chunk (r_a[CHUNK-1:0]),
    .b_chunk (r_b[CHUNK-1:0]),
    .cin     (r_carry),
    .s_chunk (w_s),
    .cout    (w_cout),
    .c_msb_in(w_cmsb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_idx   <= '0;
            r_state <= RUN;
          end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_cout;
          r_acc   <= w_acc_next;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            sum                <= w_acc_next;
            carryout           <= w_cout;
            {overflow, zero}   <= w_flags;
            r_state            <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
